// File: rtl/hazard_forward_scoreboard.sv
// hazard_forward_scoreboard
// EX-stage operand forwarding from N bypass stages plus a long-latency
// completion port, a per-register pending scoreboard, and a RUN/STALL
// state machine that keeps stall and forwarding performance counters.
module hazard_forward_scoreboard #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [REG_ADDR_W-1:0]            i_rs1_addr,
    input  logic [REG_ADDR_W-1:0]            i_rs2_addr,
    input  logic                             i_rs1_used,
    input  logic                             i_rs2_used,
    input  logic [XLEN-1:0]                  i_rs1_orig,
    input  logic [XLEN-1:0]                  i_rs2_orig,
    input  logic                             i_ex_valid,
    input  logic                             i_ex_wr_rd,
    input  logic [REG_ADDR_W-1:0]            i_ex_rd_addr,
    input  logic                             i_ex_long,
    input  logic [NUM_STAGES-1:0]            i_byp_wr,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0] i_byp_rd_addr,
    input  logic [NUM_STAGES-1:0]            i_byp_rd_valid,
    input  logic [NUM_STAGES*XLEN-1:0]       i_byp_rd,
    input  logic                             i_cmpl_valid,
    input  logic [REG_ADDR_W-1:0]            i_cmpl_rd_addr,
    input  logic [XLEN-1:0]                  i_cmpl_rd,
    input  logic                             i_flush,
    input  logic                             i_cnt_clr,
    output logic [XLEN-1:0]                  o_rs1,
    output logic [XLEN-1:0]                  o_rs2,
    output logic                             o_stall,
    output logic [2**REG_ADDR_W-1:0]         o_pending,
    output logic [CNT_W-1:0]                 o_stall_cycles,
    output logic [CNT_W-1:0]                 o_fwd_hits,
    output logic [CNT_W-1:0]                 o_max_stall
);

    localparam int NREGS = 2**REG_ADDR_W;

    typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

    // Result of resolving one operand against all forwarding sources.
    typedef struct packed {
        logic [XLEN-1:0] val;
        logic            byp_hit;   // some bypass stage matched
        logic            byp_ok;    // the winning stage has its data ready
        logic            cmpl_hit;  // completion port matched
    } opnd_t;

    // Walk stages oldest to youngest so the youngest match overrides;
    // the completion port only matters when no stage matched.
    function automatic opnd_t resolve(
        input logic [REG_ADDR_W-1:0]            addr,
        input logic [XLEN-1:0]                  orig,
        input logic [NUM_STAGES-1:0]            byp_wr,
        input logic [NUM_STAGES*REG_ADDR_W-1:0] byp_addr,
        input logic [NUM_STAGES-1:0]            byp_valid,
        input logic [NUM_STAGES*XLEN-1:0]       byp_data,
        input logic                             cmpl_valid,
        input logic [REG_ADDR_W-1:0]            cmpl_addr,
        input logic [XLEN-1:0]                  cmpl_data
    );
        opnd_t r;
        r.val      = orig;
        r.byp_hit  = 1'b0;
        r.byp_ok   = 1'b0;
        r.cmpl_hit = 1'b0;
        if (cmpl_valid && (cmpl_addr == addr)) begin
            r.val      = cmpl_data;
            r.cmpl_hit = 1'b1;
        end else begin
            r.cmpl_hit = 1'b0;
        end
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (byp_wr[k] && (byp_addr[k*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                r.val     = byp_data[k*XLEN +: XLEN];
                r.byp_hit = 1'b1;
                r.byp_ok  = byp_valid[k];
            end else begin
                r.byp_hit = r.byp_hit;
            end
        end
        // x0 is hardwired zero and never a hazard source.
        if (addr == {REG_ADDR_W{1'b0}}) begin
            r = '0;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Saturating increment shared by all counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] pending_nxt_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] stall_len_r;
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] fwd_hits_r;
    logic [CNT_W-1:0] max_stall_r;
    opnd_t            op1_s;
    opnd_t            op2_s;
    logic             haz1_s;
    logic             haz2_s;
    logic             waw_s;
    logic             stall_s;
    logic             issue_long_s;
    logic             fwd_hit_s;

    // Resolve both operands against bypass stages, completion port and regfile.
    always_comb begin
        op1_s = resolve(i_rs1_addr, i_rs1_orig, i_byp_wr, i_byp_rd_addr, i_byp_rd_valid,
                        i_byp_rd, i_cmpl_valid, i_cmpl_rd_addr, i_cmpl_rd);
        op2_s = resolve(i_rs2_addr, i_rs2_orig, i_byp_wr, i_byp_rd_addr, i_byp_rd_valid,
                        i_byp_rd, i_cmpl_valid, i_cmpl_rd_addr, i_cmpl_rd);
    end

    // Hazard detection: unready bypass, pending register, or WAW on a long op.
    always_comb begin
        haz1_s = 1'b0;
        haz2_s = 1'b0;
        waw_s  = 1'b0;
        if (i_rs1_used && (i_rs1_addr != {REG_ADDR_W{1'b0}})) begin
            haz1_s = (op1_s.byp_hit && !op1_s.byp_ok) ||
                     (pending_r[i_rs1_addr] && !op1_s.byp_hit && !op1_s.cmpl_hit);
        end else begin
            haz1_s = 1'b0;
        end
        if (i_rs2_used && (i_rs2_addr != {REG_ADDR_W{1'b0}})) begin
            haz2_s = (op2_s.byp_hit && !op2_s.byp_ok) ||
                     (pending_r[i_rs2_addr] && !op2_s.byp_hit && !op2_s.cmpl_hit);
        end else begin
            haz2_s = 1'b0;
        end
        if (i_ex_long && i_ex_wr_rd && pending_r[i_ex_rd_addr]) begin
            waw_s = !(i_cmpl_valid && (i_cmpl_rd_addr == i_ex_rd_addr));
        end else begin
            waw_s = 1'b0;
        end
        stall_s = i_ex_valid && !i_flush && (haz1_s || haz2_s || waw_s);
    end

    // Issue, forwarding-hit and next scoreboard; a same-cycle set beats the clear.
    always_comb begin
        pending_nxt_s = pending_r;
        issue_long_s  = i_ex_valid && !stall_s && !i_flush && i_ex_long && i_ex_wr_rd &&
                        (i_ex_rd_addr != {REG_ADDR_W{1'b0}});
        fwd_hit_s     = i_ex_valid && !i_flush && !stall_s &&
                        ((i_rs1_used && (op1_s.byp_hit || op1_s.cmpl_hit)) ||
                         (i_rs2_used && (op2_s.byp_hit || op2_s.cmpl_hit)));
        if (i_cmpl_valid) begin
            pending_nxt_s[i_cmpl_rd_addr] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (issue_long_s) begin
            pending_nxt_s[i_ex_rd_addr] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // RUN/STALL next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN:     state_nxt_s = stall_s ? STALL : RUN;
            STALL:   state_nxt_s = stall_s ? STALL : RUN;
            default: state_nxt_s = RUN;
        endcase
    end

    // State register and scoreboard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= RUN;
            pending_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    // Stall length tracking: restart on entering STALL, count while staying.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_len_r <= '0;
        end else if ((state_r == RUN) && stall_s) begin
            stall_len_r <= '0;
        end else if ((state_r == STALL) && stall_s) begin
            stall_len_r <= sat_inc(stall_len_r);
        end else begin
            stall_len_r <= stall_len_r;
        end
    end

    // Saturating performance counters; clear takes priority over counting.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            stall_cycles_r <= '0;
            fwd_hits_r     <= '0;
            max_stall_r    <= '0;
        end else begin
            stall_cycles_r <= stall_s ? sat_inc(stall_cycles_r) : stall_cycles_r;
            fwd_hits_r     <= fwd_hit_s ? sat_inc(fwd_hits_r) : fwd_hits_r;
            if ((state_r == STALL) && (sat_inc(stall_len_r) > max_stall_r)) begin
                max_stall_r <= sat_inc(stall_len_r);
            end else begin
                max_stall_r <= max_stall_r;
            end
        end
    end

    assign o_rs1          = op1_s.val;
    assign o_rs2          = op2_s.val;
    assign o_stall        = stall_s;
    assign o_pending      = pending_r;
    assign o_stall_cycles = stall_cycles_r;
    assign o_fwd_hits     = fwd_hits_r;
    assign o_max_stall    = max_stall_r;

endmodule
